int_ctrl: RTL and testbench

- Receiving end of the 16-line external interrupt bus `int_i` that the SoC exposes at its top level.
- Synchronises the lines, detects rising edges and latches them as pending. Applies a software mask and prioritises the result.
- Presents a single request plus ID to the RV32I core, with an ack / end-of-interrupt handshake.
- Sits inside RV32I_sopc between the top-level `int_i` pins and the core's interrupt input. Its register port is memory-mapped on the data bus.

---
 rtl/int_ctrl_pkg.sv | 18 +
 rtl/int_ctrl_prio_enc.sv | 20 ++
 rtl/int_ctrl.sv | 137 +++++++++++++
 tb/tb_int_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register map, FSM encoding
// and reset polarity.
package int_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic [1:0] IntcMask = 2'd0;
  localparam logic [1:0] IntcPend = 2'd1;
  localparam logic [1:0] IntcStat = 2'd2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } intc_state_e;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; also reused by the exception-cause logic.
module int_prio_enc #(
  parameter int unsigned NUM_IRQ = 16,
  localparam int unsigned IdW    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [IdW-1:0]     id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IdW'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// External interrupt controller: synchronise, latch rising edges as pending, mask,
// prioritise and hand one request at a time to the core with an ack/EOI handshake.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IdW        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] int_i,
  input  logic               reg_we_i,
  input  logic [1:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               irq_o,
  output logic [IdW-1:0]     irq_id_o,
  input  logic               irq_ack_i,
  input  logic               eoi_i
);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] rise, eligible, ack_clr, clr;
  intc_state_e        state_q, state_d;
  logic               irq_q, irq_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [IdW-1:0]     active_q, active_d;
  logic               enc_valid;
  logic [IdW-1:0]     enc_id;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i[31:NUM_IRQ];

  assign eligible = pend_q & mask_q;

  int_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (eligible),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], int_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    id_d     = id_q;
    active_d = active_q;
    ack_clr  = '0;
    unique case (state_q)
      StIdle: begin
        if (enc_valid) begin
          state_d = StReq;
          irq_d   = 1'b1;
          id_d    = enc_id;
        end
      end
      StReq: begin
        if (irq_ack_i) begin
          active_d = id_q;
          ack_clr  = NUM_IRQ'(1) << id_q;
          irq_d    = 1'b0;
          state_d  = StService;
        end else if (!enc_valid) begin
          irq_d   = 1'b0;
          state_d = StIdle;
        end else begin
          // Re-evaluated every cycle so a higher-priority arrival pre-empts.
          id_d = enc_id;
        end
      end
      StService: begin
        if (eoi_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clr = ack_clr;
    if (reg_we_i && reg_addr_i == IntcPend) clr = clr | reg_wdata_i[NUM_IRQ-1:0];
    // Set beats clear.
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_q;
    if (reg_we_i && reg_addr_i == IntcMask) mask_d = reg_wdata_i[NUM_IRQ-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      sync_q   <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      state_q  <= StIdle;
      irq_q    <= 1'b0;
      id_q     <= '0;
      active_q <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
      id_q     <= id_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    unique case (reg_addr_i)
      IntcMask: reg_rdata_o[NUM_IRQ-1:0] = mask_q;
      IntcPend: reg_rdata_o[NUM_IRQ-1:0] = pend_q;
      IntcStat: begin
        reg_rdata_o[0]         = irq_q;
        reg_rdata_o[2:1]       = state_q;
        reg_rdata_o[4 +: IdW]  = active_q;
      end
      default: reg_rdata_o = '0;
    endcase
  end

  assign irq_o    = irq_q;
  assign irq_id_o = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued as stimulus is applied and
// compared as DUT outputs are sampled.
module tb_int_ctrl;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] int_i;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        irq_o;
  logic [3:0]  irq_id_o;
  logic        irq_ack_i;
  logic        eoi_i;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] d;

  always #5 clk = ~clk;

  int_ctrl #(
    .NUM_IRQ     (16),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .int_i       (int_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o),
    .irq_ack_i   (irq_ack_i),
    .eoi_i       (eoi_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0x%0h expected none", obs);
    end else begin
      check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    reg_addr_i = a;
    #1;
    v = reg_rdata_o;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    reg_we_i    = 1'b1;
    reg_addr_i  = a;
    reg_wdata_i = v;
    step();
    reg_we_i    = 1'b0;
    reg_wdata_i = '0;
  endtask

  task automatic pulse_int(input logic [15:0] m);
    int_i = m;
    step();
    int_i = '0;
  endtask

  task automatic ack();
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
  endtask

  task automatic eoi();
    eoi_i = 1'b1;
    step();
    eoi_i = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic req, input logic [3:0] id);
    expect_v({tag, "_irq"}, 32'(req));
    if (req) expect_v({tag, "_id"}, 32'(id));
    observe(32'(irq_o));
    if (req) observe(32'(irq_id_o));
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
    expect_v(tag, v);
    rd(a, d);
    observe(d);
  endtask

  initial begin
    rst = 1'b1; int_i = '0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
    irq_ack_i = 1'b0; eoi_i = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_irq("rst", 1'b0, 4'd0);
    check_eq("rst_id", 32'(irq_id_o), 32'd0);
    chk_reg("rst_mask", 2'd0, 32'h0);
    chk_reg("rst_pend", 2'd1, 32'h0);
    chk_reg("rst_stat", 2'd2, 32'h0);

    // 1: single line, exact latency and handshake
    wr(2'd0, 32'hFFFF_FFFF);
    chk_reg("t1_mask", 2'd0, 32'h0000_FFFF);
    pulse_int(16'h0020);
    for (int k = 0; k < S; k++) step();
    chk_irq("t1_early", 1'b0, 4'd0);
    step();
    chk_irq("t1_req", 1'b1, 4'd5);
    ack();
    chk_irq("t1_ack", 1'b0, 4'd0);
    chk_reg("t1_pend", 2'd1, 32'h0);
    chk_reg("t1_stat_svc", 2'd2, 32'h54);
    eoi();
    chk_reg("t1_stat_idle", 2'd2, 32'h50);

    // 2: simultaneous lines, lowest index first, re-request after EOI
    pulse_int(16'h0208);
    for (int k = 0; k <= S; k++) step();
    chk_irq("t2_req3", 1'b1, 4'd3);
    ack();
    chk_reg("t2_pend", 2'd1, 32'h0200);
    eoi();
    chk_irq("t2_eoi", 1'b0, 4'd0);
    step();
    chk_irq("t2_req9", 1'b1, 4'd9);
    ack(); eoi();

    // 3: masked line latches pending; unmask raises it
    wr(2'd0, 32'h0);
    pulse_int(16'h0080);
    for (int k = 0; k < S + 2; k++) step();
    chk_reg("t3_pend", 2'd1, 32'h0080);
    chk_irq("t3_masked", 1'b0, 4'd0);
    wr(2'd0, 32'h0080);
    chk_irq("t3_unmask0", 1'b0, 4'd0);
    step();
    chk_irq("t3_req7", 1'b1, 4'd7);
    ack(); eoi();
    wr(2'd0, 32'hFFFF);

    // 4: pre-emption before ack
    pulse_int(16'h0100);
    for (int k = 0; k <= S; k++) step();
    chk_irq("t4_req8", 1'b1, 4'd8);
    pulse_int(16'h0004);
    for (int k = 0; k <= S; k++) step();
    chk_irq("t4_req2", 1'b1, 4'd2);
    ack();
    chk_reg("t4_pend", 2'd1, 32'h0100);
    eoi();
    step();
    chk_irq("t4_req8b", 1'b1, 4'd8);
    ack(); eoi();

    // 5: W1C vs. coincident edge, then W1C on a quiet line
    pulse_int(16'h0010);
    for (int k = 0; k < S + 2; k++) step();
    chk_reg("t5_pend_a", 2'd1, 32'h0010);
    pulse_int(16'h0010);
    for (int k = 0; k < S - 1; k++) step();
    wr(2'd1, 32'h0010);
    chk_reg("t5_set_wins", 2'd1, 32'h0010);
    for (int k = 0; k < S + 2; k++) step();
    wr(2'd1, 32'h0010);
    chk_reg("t5_cleared", 2'd1, 32'h0);
    step();
    chk_irq("t5_withdrawn", 1'b0, 4'd0);

    // 6: reset while in SERVICE, then stray handshakes
    pulse_int(16'h0002);
    for (int k = 0; k <= S; k++) step();
    ack();
    chk_reg("t6_stat_svc", 2'd2, 32'h14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_irq("t6_rst", 1'b0, 4'd0);
    chk_reg("t6_pend", 2'd1, 32'h0);
    chk_reg("t6_mask", 2'd0, 32'h0);
    chk_reg("t6_stat", 2'd2, 32'h0);
    eoi();
    chk_reg("t6_stray_eoi", 2'd2, 32'h0);
    ack();
    chk_reg("t6_stray_ack", 2'd2, 32'h0);
    chk_reg("t6_addr3", 2'd3, 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
